title_screen: RTL and testbench
===============================

// Module: title_screen
// PURPOSE
//  Title-screen pixel generator for Dino Run. For the current VGA scan coordinate
//  it returns a 1-bit "lit" value (white on black). Static text "DINO RUN" sits
//  above a blinking prompt "PRESS SPACE". It drives the pixel mux ahead of the RGB
//  output stage while the game is in its title state.
// PARAMETERS
//  TitleScale   4    integer magnification of the 8x8 glyphs in "DINO RUN"
//  PromptScale  2    integer magnification of the glyphs in "PRESS SPACE"
//  BlinkFrames  30   frames per prompt blink phase (on for N frames, then off for N)
// PORTS
//  clk_i      in   1   system clock
//  rst_i      in   1   synchronous, active-high reset
//  pixel_x_i  in   10  current column, 0..ScreenWidth-1 (640, from dinorun_pkg)
//  pixel_y_i  in   10  current row, 0..ScreenHeight-1 (480, from dinorun_pkg)
//  pixel_o    out  1   1 = white pixel at (pixel_x_i, pixel_y_i), 0 = black
// BEHAVIOUR
//  - One clock domain; synchronous, active-high reset on rst_i.
//  - pixel_o is combinational from pixel_x/y_i and the blink state; zero latency.
//  - Font: public-domain font8x8_basic (8x8 cells). Bit 0 of each row byte is the
//    leftmost column, and row 0 is the top row. It is held in an internal case ROM
//    covering D I N O R U P E S A C and space. Space is all zeros.
//  - Title box: 8 chars x 8*TitleScale px = 256x32 at x0=192, y0=160
//    (x 192..447, y 160..191). Centring rule: x0 = (ScreenWidth - width)/2.
//  - Prompt box: 11 chars x 8*PromptScale px = 176x16 at x0=232, y0=288
//    (x 232..407, y 288..303).
//  - Within a box: dx = x - x0 and dy = y - y0. The character index is dx/(8*S).
//    The glyph column is (dx/S)%8 and the glyph row is dy/S. S is a power of two,
//    so these reduce to shifts and masks. No multipliers are allowed.
//  - Title pixel: lit iff the glyph bit is 1. Prompt pixel: lit iff the glyph bit is
//    1 and blink_on=1.
//  - All coordinates outside both boxes give 0, including x>=640 or y>=480.
//  - Frame detection: reg at_origin_q <= (x==0 && y==0). frame_tick is asserted on
//    the rising edge of (x==0 && y==0), i.e. once per frame even if the origin is
//    held for several clocks.
//  - Blink: frame_cnt counts 0..BlinkFrames-1 on frame_tick. It wraps to 0 and
//    toggles blink_on when it reaches BlinkFrames-1.
//  - Reset: frame_cnt=0, blink_on=1 (prompt visible), at_origin_q=0. pixel_o is
//    still driven during reset: the title follows the coordinates and the prompt
//    follows blink_on=1.
//  - Reset mid-frame takes effect on the next clock edge. There is no other state.
// TESTING
//  - Reset, then scan the full 640x480 -> pixels are lit only inside the two boxes,
//    and at least one pixel is lit in each box.
//  - 'D' row0 = 0x1F: (192..211,160..163) -> pixel_o=1; (212,160) -> 0;
//    (191,160) -> 0.
//  - Space glyph: x 320..351 (char 4 of title), y 160..191 -> pixel_o=0 everywhere.
//  - Boundary: (447,191) and (448,191) are both 0 for 'N' col7; (639,479) -> 0;
//    (700,100) -> 0.
//  - Blink: 30 origin pulses -> the prompt pixel at 'P' row0 (232,288) goes 1->0;
//    30 more pulses -> it returns to 1. Holding the origin for 5 clocks counts
//    one frame.
//  - Assert rst_i while the prompt is off -> on the next clock the prompt is
//    visible and frame_cnt=0.

Source files
------------

// File: rtl/title_screen.sv
// Title-screen pixel generator: static "DINO RUN" banner above a blinking
// "PRESS SPACE" prompt, rendered from an 8x8 font ROM with power-of-two scaling.
module title_screen #(
    parameter int TitleScale  = 4,
    parameter int PromptScale = 2,
    parameter int BlinkFrames = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] pixel_x_i,
    input  logic [9:0] pixel_y_i,
    output logic       pixel_o
);

    localparam int ScreenWidth = 640;

    localparam int TitleShift = $clog2(TitleScale);
    localparam int TitleW     = 8 * 8 * TitleScale;
    localparam int TitleH     = 8 * TitleScale;
    localparam int TitleX0    = (ScreenWidth - TitleW) / 2;
    localparam int TitleY0    = 160;

    localparam int PromptShift = $clog2(PromptScale);
    localparam int PromptW     = 11 * 8 * PromptScale;
    localparam int PromptH     = 8 * PromptScale;
    localparam int PromptX0    = (ScreenWidth - PromptW) / 2;
    localparam int PromptY0    = 288;

    localparam int CntW = $clog2(BlinkFrames);

    typedef enum logic [3:0] {
        GlyphSpace, GlyphD, GlyphI, GlyphN, GlyphO, GlyphR,
        GlyphU, GlyphP, GlyphE, GlyphS, GlyphA, GlyphC
    } glyph_e;

    // Glyphs packed row 7 down to row 0, so row r lives at bits [8r+7:8r].
    function automatic logic [7:0] glyphRow(input glyph_e glyph, input logic [2:0] row);
        logic [63:0] bits;
        bits = '0;
        case (glyph)
            GlyphD:  bits = {8'h00, 8'h1F, 8'h36, 8'h66, 8'h66, 8'h66, 8'h36, 8'h1F};
            GlyphI:  bits = {8'h00, 8'h1E, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h1E};
            GlyphN:  bits = {8'h00, 8'h63, 8'h63, 8'h73, 8'h7B, 8'h6F, 8'h67, 8'h63};
            GlyphO:  bits = {8'h00, 8'h1C, 8'h36, 8'h63, 8'h63, 8'h63, 8'h36, 8'h1C};
            GlyphR:  bits = {8'h00, 8'h67, 8'h66, 8'h36, 8'h3E, 8'h66, 8'h66, 8'h3F};
            GlyphU:  bits = {8'h00, 8'h3F, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
            GlyphP:  bits = {8'h00, 8'h0F, 8'h06, 8'h06, 8'h3E, 8'h66, 8'h66, 8'h3F};
            GlyphE:  bits = {8'h00, 8'h7F, 8'h46, 8'h16, 8'h1E, 8'h16, 8'h46, 8'h7F};
            GlyphS:  bits = {8'h00, 8'h1E, 8'h33, 8'h38, 8'h0E, 8'h07, 8'h33, 8'h1E};
            GlyphA:  bits = {8'h00, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h1E, 8'h0C};
            GlyphC:  bits = {8'h00, 8'h3C, 8'h66, 8'h03, 8'h03, 8'h03, 8'h66, 8'h3C};
            default: bits = '0;
        endcase
        return bits[{row, 3'b000} +: 8];
    endfunction

    function automatic glyph_e titleChar(input logic [2:0] idx);
        glyph_e g;
        g = GlyphSpace;
        case (idx)
            3'd0:    g = GlyphD;
            3'd1:    g = GlyphI;
            3'd2:    g = GlyphN;
            3'd3:    g = GlyphO;
            3'd5:    g = GlyphR;
            3'd6:    g = GlyphU;
            3'd7:    g = GlyphN;
            default: g = GlyphSpace;
        endcase
        return g;
    endfunction

    function automatic glyph_e promptChar(input logic [3:0] idx);
        glyph_e g;
        g = GlyphSpace;
        case (idx)
            4'd0:    g = GlyphP;
            4'd1:    g = GlyphR;
            4'd2:    g = GlyphE;
            4'd3:    g = GlyphS;
            4'd4:    g = GlyphS;
            4'd6:    g = GlyphS;
            4'd7:    g = GlyphP;
            4'd8:    g = GlyphA;
            4'd9:    g = GlyphC;
            4'd10:   g = GlyphE;
            default: g = GlyphSpace;
        endcase
        return g;
    endfunction

    logic [9:0] w_titleDx, w_titleDy, w_promptDx, w_promptDy;
    logic       w_inTitle, w_inPrompt;
    logic [2:0] w_titleCol, w_titleRow, w_promptCol, w_promptRow;
    logic [7:0] w_titleRowBits, w_promptRowBits;
    logic       w_atOrigin, w_frameTick;

    logic            r_atOrigin;
    logic            r_blinkOn;
    logic [CntW-1:0] r_frameCnt;

    assign w_titleDx  = pixel_x_i - 10'(TitleX0);
    assign w_titleDy  = pixel_y_i - 10'(TitleY0);
    assign w_promptDx = pixel_x_i - 10'(PromptX0);
    assign w_promptDy = pixel_y_i - 10'(PromptY0);

    assign w_inTitle = (pixel_x_i >= 10'(TitleX0)) && (pixel_x_i < 10'(TitleX0 + TitleW)) &&
                       (pixel_y_i >= 10'(TitleY0)) && (pixel_y_i < 10'(TitleY0 + TitleH));
    assign w_inPrompt = (pixel_x_i >= 10'(PromptX0)) && (pixel_x_i < 10'(PromptX0 + PromptW)) &&
                        (pixel_y_i >= 10'(PromptY0)) && (pixel_y_i < 10'(PromptY0 + PromptH));

    // Scale factors are powers of two, so character/column/row split is pure shifting.
    assign w_titleCol  = 3'(w_titleDx >> TitleShift);
    assign w_titleRow  = 3'(w_titleDy >> TitleShift);
    assign w_promptCol = 3'(w_promptDx >> PromptShift);
    assign w_promptRow = 3'(w_promptDy >> PromptShift);

    assign w_titleRowBits  = glyphRow(titleChar(3'(w_titleDx >> (TitleShift + 3))), w_titleRow);
    assign w_promptRowBits = glyphRow(promptChar(4'(w_promptDx >> (PromptShift + 3))), w_promptRow);

    assign pixel_o = (w_inTitle && w_titleRowBits[w_titleCol]) ||
                     (w_inPrompt && w_promptRowBits[w_promptCol] && r_blinkOn);

    assign w_atOrigin  = (pixel_x_i == 10'd0) && (pixel_y_i == 10'd0);
    assign w_frameTick = w_atOrigin && !r_atOrigin;

    // One frame per rising edge of the origin; the prompt toggles every BlinkFrames frames.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_atOrigin <= 1'b0;
            r_frameCnt <= '0;
            r_blinkOn  <= 1'b1;
        end else begin
            r_atOrigin <= w_atOrigin;
            if (w_frameTick) begin
                if (r_frameCnt == CntW'(BlinkFrames - 1)) begin
                    r_frameCnt <= '0;
                    r_blinkOn  <= ~r_blinkOn;
                end else begin
                    r_frameCnt <= r_frameCnt + CntW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_title_screen.sv
// Scoreboard bench for title_screen: directed pixel vectors plus origin-pulse
// sequences driving the prompt blink, checked by an independent negedge monitor.
module tb_title_screen;

    typedef struct {
        string name;
        logic  expected;
        int    region;
        int    px;
        int    py;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pixelX = '0;
    logic [9:0] pixelY = '0;
    logic       pixelOut;

    logic  tbValid = 1'b0;
    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    litTitle = 0;
    int    litPrompt = 0;

    title_screen dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .pixel_x_i(pixelX),
        .pixel_y_i(pixelY),
        .pixel_o  (pixelOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input item_t it, input logic actual);
        checks++;
        if (actual !== it.expected) begin
            errors++;
            $display("[TB] FAIL %s at (%0d,%0d): pixel_o=%0b expected %0b",
                     it.name, it.px, it.py, actual, it.expected);
        end
    endtask

    // Monitor: one sample per presented vector, on the falling edge.
    always @(negedge clk) begin
        if (tbValid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underflow: queue empty, required an entry");
            end else begin
                item_t it;
                it = sb.pop_front();
                if (it.region == 1) begin
                    if (pixelOut === 1'b1) litTitle++;
                end else if (it.region == 2) begin
                    if (pixelOut === 1'b1) litPrompt++;
                end else begin
                    checkOutput(it, pixelOut);
                end
            end
        end
    end

    task automatic pushItem(input string name, input int x, input int y,
                            input logic expected, input int region);
        item_t it;
        it.name = name;
        it.expected = expected;
        it.region = region;
        it.px = x;
        it.py = y;
        sb.push_back(it);
    endtask

    task automatic applyStimulus(input string name, input int x, input int y,
                                 input logic expected);
        @(posedge clk);
        #1;
        pixelX = 10'(x);
        pixelY = 10'(y);
        pushItem(name, x, y, expected, 0);
        tbValid = 1'b1;
    endtask

    task automatic applyRegion(input int x, input int y, input int region);
        @(posedge clk);
        #1;
        pixelX = 10'(x);
        pixelY = 10'(y);
        pushItem("scan", x, y, 1'b0, region);
        tbValid = 1'b1;
    endtask

    task automatic originPulse(input int hold);
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        pixelX = 10'd0;
        pixelY = 10'd0;
        repeat (hold - 1) @(posedge clk);
        @(posedge clk);
        #1;
        pixelX = 10'd1;
        pixelY = 10'd0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) originPulse(1);
    endtask

    initial begin
        // Reset held: output still follows coordinates, prompt visible.
        rst = 1'b1;
        applyStimulus("reset_title_D", 192, 160, 1'b1);
        applyStimulus("reset_prompt_P", 232, 288, 1'b1);
        applyStimulus("reset_outside", 100, 100, 1'b0);
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        rst = 1'b0;

        // Coarse full-screen scan: strictly dark outside both boxes.
        for (int y = 0; y < 480; y += 4) begin
            for (int x = 0; x < 640; x += 4) begin
                if (x >= 192 && x <= 447 && y >= 160 && y <= 191)
                    applyRegion(x, y, 1);
                else if (x >= 232 && x <= 407 && y >= 288 && y <= 303)
                    applyRegion(x, y, 2);
                else
                    applyStimulus("scan_outside", x, y, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        @(posedge clk);
        checks++;
        if (litTitle == 0) begin
            errors++;
            $display("[TB] FAIL scan_title_lit: lit count %0d, required > 0", litTitle);
        end
        checks++;
        if (litPrompt == 0) begin
            errors++;
            $display("[TB] FAIL scan_prompt_lit: lit count %0d, required > 0", litPrompt);
        end

        doReset();

        // 'D' row 0 = 0x1F: five lit columns, 4x magnified.
        for (int y = 160; y <= 163; y++)
            for (int x = 192; x <= 211; x++)
                applyStimulus("D_row0", x, y, 1'b1);
        applyStimulus("D_row0_right", 212, 160, 1'b0);
        applyStimulus("D_left_edge", 191, 160, 1'b0);

        // Space character of the title.
        for (int y = 160; y <= 191; y++)
            for (int x = 320; x <= 351; x++)
                applyStimulus("title_space", x, y, 1'b0);

        // Other hand-decoded glyph bits.
        applyStimulus("I_row0_col0", 224, 160, 1'b0);
        applyStimulus("I_row0_col1", 228, 160, 1'b1);
        applyStimulus("O_row2_col0", 288, 168, 1'b1);
        applyStimulus("O_row2_col2", 296, 168, 1'b0);
        applyStimulus("N_row0_col6", 440, 160, 1'b1);
        applyStimulus("N_row0_col7", 444, 160, 1'b0);
        applyStimulus("R_row6_col0", 352, 184, 1'b1);
        applyStimulus("R_row7", 352, 188, 1'b0);
        applyStimulus("N_col7_corner", 447, 191, 1'b0);
        applyStimulus("past_title", 448, 191, 1'b0);
        applyStimulus("screen_corner", 639, 479, 1'b0);
        applyStimulus("offscreen", 700, 100, 1'b0);
        applyStimulus("P_row0_col0", 232, 288, 1'b1);
        applyStimulus("prompt_left", 231, 288, 1'b0);
        applyStimulus("A_row0_col0", 360, 288, 1'b0);
        applyStimulus("A_row0_col2", 364, 288, 1'b1);
        applyStimulus("E_row0_col6", 404, 288, 1'b1);
        applyStimulus("E_row0_col7", 406, 288, 1'b0);
        applyStimulus("prompt_right", 408, 288, 1'b0);
        applyStimulus("P_row6_col0", 232, 300, 1'b1);
        applyStimulus("P_row7", 232, 303, 1'b0);
        applyStimulus("prompt_below", 232, 304, 1'b0);

        // Blink: 30 frames on, 30 frames off.
        pulses(29);
        applyStimulus("blink_29_on", 232, 288, 1'b1);
        pulses(1);
        applyStimulus("blink_30_off", 232, 288, 1'b0);
        applyStimulus("blink_title_stays", 192, 160, 1'b1);
        pulses(29);
        applyStimulus("blink_59_off", 232, 288, 1'b0);
        pulses(1);
        applyStimulus("blink_60_on", 232, 288, 1'b1);

        // A held origin counts as a single frame.
        doReset();
        pulses(28);
        originPulse(5);
        applyStimulus("hold_counts_one", 232, 288, 1'b1);
        pulses(1);
        applyStimulus("hold_then_off", 232, 288, 1'b0);

        // Reset while the prompt is off restores it and clears the frame count.
        pulses(5);
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        rst = 1'b1;
        applyStimulus("reset_restores_prompt", 232, 288, 1'b1);
        @(posedge clk);
        #1;
        tbValid = 1'b0;
        rst = 1'b0;
        pulses(29);
        applyStimulus("reset_cnt_cleared", 232, 288, 1'b1);
        pulses(1);
        applyStimulus("reset_cnt_wrap", 232, 288, 1'b0);

        @(posedge clk);
        #1;
        tbValid = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
